instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter IMEM_DEPTH, default 256, instruction memory depth in words; AW = $clog2(IMEM_DEPTH).
REQ-002 Parameter WDT_CYCLES, default 64, watchdog limit in cycles (used only with SEQ_WATCHDOG_EN).
REQ-003 CLK  in  1  clock; all logic on posedge.
REQ-004 RSTN  in  1  reset, synchronous, active-low.
REQ-005 START  in  1  host pulse; begins a program run at address 0.
REQ-006 IMEM_RD  out  1  instruction memory read strobe.
REQ-007 IMEM_ADDR  out  AW  instruction memory read address (= PC).
REQ-008 IMEM_DATA  in  32  read data, valid exactly one cycle after IMEM_RD.
REQ-009 INSTR  out  32  instruction issued to the control unit.
REQ-010 ONSWT  out  1  hold/run request to the control unit.
REQ-011 DONE  in  1  control unit completion flag.
REQ-012 OFFSWT  in  1  control unit shutdown request.
REQ-013 BUSY  out  1  high from the cycle after START acceptance until HALTED.
REQ-014 HALTED  out  1  high after a run ends; cleared on START.
REQ-015 ERR  out  1  sticky error (illegal opcode or watchdog); cleared on START.
REQ-016 PC  out  AW  current program counter.

Function
REQ-017 Instruction fields: [2:0] opcode (0 NOP, 1 FETCHB, 2 FETCHA, 3 MATMUL, 4 STORE; 5-7 illegal); [6:3] index; [7] halt.
REQ-018 States: S_IDLE, S_FETCH, S_WAIT_RD, S_ISSUE, S_WAIT_DONE, S_HALT.
REQ-019 S_IDLE/S_HALT: START=1 -> PC=0, ERR=0, HALTED=0, go to S_FETCH; START while BUSY is ignored.
REQ-020 S_FETCH: IMEM_RD=1 for one cycle with IMEM_ADDR=PC, then S_WAIT_RD.
REQ-021 S_WAIT_RD: capture IMEM_DATA, then S_ISSUE; START edge t gives INSTR/ONSWT valid at t+3.
REQ-022 S_ISSUE: legal opcode -> drive INSTR=captured word, ONSWT=1, go to S_WAIT_DONE; illegal opcode -> set ERR, do not issue, and advance PC to S_FETCH.
REQ-023 S_WAIT_DONE: INSTR and ONSWT are held stable; DONE is ignored in the first cycle (registered control-unit outputs) and sampled from the second cycle onward.
REQ-024 On a sampled DONE=1: ONSWT=0 and INSTR=32'h0 for one cycle.
REQ-025 After the REQ-024 cycle, the halt bit set -> S_HALT; otherwise PC+1 -> S_FETCH.
REQ-026 OFFSWT=1 in any busy state -> S_HALT next cycle, ONSWT=0, INSTR=32'h0; OFFSWT takes priority over a simultaneous DONE.
REQ-027 PC wraps from IMEM_DEPTH-1 to 0 without error.
REQ-028 NOP opcode is issued like any legal opcode and completes on DONE.
REQ-029 S_HALT: HALTED=1 and BUSY=0; the block stays there until START.

Reset
REQ-030 RSTN=0 at a clock edge -> state S_IDLE, PC=0, INSTR=32'h0, ONSWT=0, IMEM_RD=0, BUSY=0, HALTED=0, ERR=0, watchdog count=0.
REQ-031 Reset mid-run aborts the run with no further memory reads.

Configuration
REQ-032 Macro SEQ_WATCHDOG_EN defined: a counter runs in S_WAIT_DONE and clears on state entry; reaching WDT_CYCLES -> ERR=1, ONSWT=0, S_HALT.
REQ-033 Macro SEQ_WATCHDOG_EN undefined: no counter; S_WAIT_DONE waits indefinitely; ERR reflects illegal opcodes only.

Structure
REQ-034 Package simd_seq_pkg holds the opcode enum, state enum, instruction field bit positions and the NOP constant.
REQ-035 Sub-module seq_watchdog (count, clear, expire) is instantiated only under SEQ_WATCHDOG_EN.

Verification
REQ-036 Program {FETCHB idx3, FETCHA idx5, MATMUL, STORE|halt}; DONE given 2 cycles after each issue -> four issues in order, PC 0..3, HALTED=1, ERR=0.
REQ-037 Opcode 6 at address 1 -> ERR=1, no ONSWT for that word, and the word at address 2 is issued next.
REQ-038 DONE held high at issue -> not accepted in the first S_WAIT_DONE cycle, accepted in the second.
REQ-039 OFFSWT and DONE asserted in the same cycle -> S_HALT, PC not incremented.
REQ-040 With SEQ_WATCHDOG_EN and WDT_CYCLES=64, DONE never asserted -> ERR=1 and HALTED=1 64 cycles after issue; without the macro, still waiting at cycle 1000.
REQ-041 RSTN low during S_WAIT_DONE, then START -> all outputs at reset values, then a fetch at address 0.

Source files
------------

// File: rtl/simd_seq_pkg.sv
// Shared types and constants for the instruction sequencer: opcodes, FSM states,
// instruction field positions and the cleared/NOP instruction word.
package simd_seq_pkg;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_FETCHB = 3'd1,
        OP_FETCHA = 3'd2,
        OP_MATMUL = 3'd3,
        OP_STORE  = 3'd4
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_RD,
        S_ISSUE,
        S_WAIT_DONE,
        S_HALT
    } state_e;

    // Sub-phases of S_WAIT_DONE: DONE blind cycle, DONE sampling, post-DONE idle cycle.
    typedef enum logic [1:0] {
        WD_FIRST,
        WD_SAMPLE,
        WD_ACK
    } wd_phase_e;

    localparam int OPC_LSB  = 0;
    localparam int OPC_MSB  = 2;
    localparam int IDX_LSB  = 3;
    localparam int IDX_MSB  = 6;
    localparam int HALT_BIT = 7;

    localparam logic [31:0] INSTR_NOP = 32'h0;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_STORE;
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Watchdog for the sequencer's DONE wait: counts while clear is low and flags
// expire once LIMIT cycles have elapsed since clear last dropped.
module seq_watchdog #(
    parameter  int LIMIT = 64,
    localparam int CW    = $clog2(LIMIT + 1)
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic clear,
    output logic expire
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expire = !clear && (count_q == CW'(LIMIT - 1));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (!expire) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches words from IMEM, issues legal ones to the control
// unit and waits for DONE. Optional DONE watchdog under macro SEQ_WATCHDOG_EN.
module instr_sequencer
    import simd_seq_pkg::*;
#(
    parameter  int IMEM_DEPTH = 256,
    parameter  int WDT_CYCLES = 64,
    localparam int AW         = $clog2(IMEM_DEPTH)
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          START,
    output logic          IMEM_RD,
    output logic [AW-1:0] IMEM_ADDR,
    input  logic [31:0]   IMEM_DATA,
    output logic [31:0]   INSTR,
    output logic          ONSWT,
    input  logic          DONE,
    input  logic          OFFSWT,
    output logic          BUSY,
    output logic          HALTED,
    output logic          ERR,
    output logic [AW-1:0] PC,
    output state_e        DBG_STATE
);

    state_e        state_q, state_d;
    wd_phase_e     phase_q, phase_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [31:0]   ir_q, ir_d;
    logic [31:0]   instr_q, instr_d;
    logic          onswt_q, onswt_d;
    logic          err_q, err_d;

    logic          busy;
    logic          wdt_expire;
    logic [AW-1:0] pc_inc;

    assign busy   = (state_q == S_FETCH) || (state_q == S_WAIT_RD) ||
                    (state_q == S_ISSUE) || (state_q == S_WAIT_DONE);
    assign pc_inc = (pc_q == AW'(IMEM_DEPTH - 1)) ? '0 : pc_q + 1'b1;

`ifdef SEQ_WATCHDOG_EN
    seq_watchdog #(
        .LIMIT (WDT_CYCLES)
    ) u_wdt (
        .CLK    (CLK),
        .RSTN   (RSTN),
        .clear  (state_q != S_WAIT_DONE),
        .expire (wdt_expire)
    );
`else
    logic wdt_unused;
    assign wdt_unused = ^WDT_CYCLES;
    assign wdt_expire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        instr_d = instr_q;
        onswt_d = onswt_q;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (START) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    err_d   = 1'b0;
                end
            end
            S_FETCH:   state_d = S_WAIT_RD;
            S_WAIT_RD: begin
                ir_d    = IMEM_DATA;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (op_legal(ir_q[OPC_MSB:OPC_LSB])) begin
                    instr_d = ir_q;
                    onswt_d = 1'b1;
                    phase_d = WD_FIRST;
                    state_d = S_WAIT_DONE;
                end else begin
                    err_d   = 1'b1;
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_WAIT_DONE: begin
                // The control unit's DONE is registered, so the first cycle may still show the previous op.
                unique case (phase_q)
                    WD_FIRST:  phase_d = WD_SAMPLE;
                    WD_SAMPLE: begin
                        if (DONE) begin
                            onswt_d = 1'b0;
                            instr_d = INSTR_NOP;
                            phase_d = WD_ACK;
                        end
                    end
                    default: begin
                        if (ir_q[HALT_BIT]) begin
                            state_d = S_HALT;
                        end else begin
                            pc_d    = pc_inc;
                            state_d = S_FETCH;
                        end
                    end
                endcase
                if (wdt_expire) begin
                    err_d   = 1'b1;
                    onswt_d = 1'b0;
                    instr_d = INSTR_NOP;
                    pc_d    = pc_q;
                    state_d = S_HALT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Shutdown wins over everything else, including a DONE in the same cycle.
        if (OFFSWT && busy) begin
            state_d = S_HALT;
            onswt_d = 1'b0;
            instr_d = INSTR_NOP;
            pc_d    = pc_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q <= S_IDLE;
            phase_q <= WD_FIRST;
            pc_q    <= '0;
            ir_q    <= INSTR_NOP;
            instr_q <= INSTR_NOP;
            onswt_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            instr_q <= instr_d;
            onswt_q <= onswt_d;
            err_q   <= err_d;
        end
    end

    assign IMEM_RD   = (state_q == S_FETCH);
    assign IMEM_ADDR = pc_q;
    assign INSTR     = instr_q;
    assign ONSWT     = onswt_q;
    assign BUSY      = busy;
    assign HALTED    = (state_q == S_HALT);
    assign ERR       = err_q;
    assign PC        = pc_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: IMEM model, control-unit responder and a program-walking
// reference model that predicts fetches, issues, final PC/ERR and run length.
module tb_instr_sequencer;
  import simd_seq_pkg::*;

  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int WDT   = 64;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic          START = 1'b0;
  logic          IMEM_RD;
  logic [AW-1:0] IMEM_ADDR;
  logic [31:0]   IMEM_DATA;
  logic [31:0]   INSTR;
  logic          ONSWT;
  logic          DONE = 1'b0;
  logic          OFFSWT = 1'b0;
  logic          BUSY;
  logic          HALTED;
  logic          ERR;
  logic [AW-1:0] PC;
  state_e        dbg_state;

  logic [31:0]   mem [0:DEPTH-1];
  logic [31:0]   exp_q[$];
  logic [AW-1:0] fetch_q[$];
  int total = 0;
  int bad   = 0;

  instr_sequencer #(.IMEM_DEPTH(DEPTH), .WDT_CYCLES(WDT)) dut (
    .CLK(CLK), .RSTN(RSTN), .START(START),
    .IMEM_RD(IMEM_RD), .IMEM_ADDR(IMEM_ADDR), .IMEM_DATA(IMEM_DATA),
    .INSTR(INSTR), .ONSWT(ONSWT), .DONE(DONE), .OFFSWT(OFFSWT),
    .BUSY(BUSY), .HALTED(HALTED), .ERR(ERR), .PC(PC), .DBG_STATE(dbg_state)
  );

  // clock / memory model
  always #5 CLK = ~CLK;
  always @(posedge CLK) if (IMEM_RD === 1'b1) IMEM_DATA <= mem[IMEM_ADDR];

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic fill_mem(input logic [31:0] w);
    for (int i = 0; i < DEPTH; i++) mem[i] = w;
  endtask

  task automatic pulse_start;
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  task automatic wait_issue(input string tag);
    int k;
    k = 0;
    while (ONSWT !== 1'b1 && k < 50) begin
      step();
      k++;
    end
    total++;
    if (ONSWT !== 1'b1) begin
      bad++;
      $display("FAIL %s issue_timeout: ONSWT=%b want 1 within 50 cycles", tag, ONSWT);
    end
  endtask

  // Runs the program in mem from address 0; DONE rises d cycles after issue (d=0: DONE held high).
  task automatic run_program(input int d, input bit noise, input string tag);
    int addr, cyc, n, w_obs, w_exp;
    bit err_m, prev_on, halted_seen;
    logic [31:0] word, prev_instr, exp_w;
    logic [AW-1:0] fa;
    exp_q.delete();
    fetch_q.delete();
    addr = 0; cyc = 0; err_m = 0;
    w_exp = (d > 2) ? d : 2;
    for (int s = 0; s < 600; s++) begin
      word = mem[addr];
      fetch_q.push_back(AW'(addr));
      if (word[2:0] > 3'd4) begin
        err_m = 1;
        cyc += 3;
        addr = (addr + 1) % DEPTH;
      end else begin
        exp_q.push_back(word);
        cyc += 4 + w_exp;
        if (word[7]) break;
        addr = (addr + 1) % DEPTH;
      end
    end

    pulse_start();
    n = 0; prev_on = 0; w_obs = 0; prev_instr = 32'h0; halted_seen = 0;
    while (n <= cyc + 20) begin
      if (HALTED === 1'b1) begin
        halted_seen = 1;
        break;
      end
      if (IMEM_RD === 1'b1) begin
        total++;
        if (fetch_q.size() == 0) begin
          bad++;
          $display("FAIL %s fetch_extra: got addr %0d want no fetch", tag, IMEM_ADDR);
        end else begin
          fa = fetch_q.pop_front();
          if (IMEM_ADDR !== fa) begin
            bad++;
            $display("FAIL %s fetch_addr: got %0d want %0d", tag, IMEM_ADDR, fa);
          end
        end
      end
      if (ONSWT === 1'b1 && !prev_on) begin
        total++;
        w_obs = 1;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL %s issue_extra: got %h want no issue", tag, INSTR);
        end else begin
          exp_w = exp_q.pop_front();
          if (INSTR !== exp_w) begin
            bad++;
            $display("FAIL %s issue_word: got %h want %h", tag, INSTR, exp_w);
          end
        end
      end else if (ONSWT === 1'b1 && prev_on) begin
        w_obs++;
        total++;
        if (INSTR !== prev_instr) begin
          bad++;
          $display("FAIL %s instr_stable: got %h want %h", tag, INSTR, prev_instr);
        end
      end else if (ONSWT !== 1'b1 && prev_on) begin
        total++;
        if (w_obs !== w_exp) begin
          bad++;
          $display("FAIL %s onswt_width: got %0d want %0d", tag, w_obs, w_exp);
        end
      end
      prev_on = (ONSWT === 1'b1);
      prev_instr = INSTR;
      DONE = (d == 0) ? 1'b1 : (ONSWT === 1'b1 && w_obs >= d);
      START = (noise && BUSY === 1'b1) ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      n++;
    end
    DONE = 1'b0;
    START = 1'b0;

    total++;
    if (!halted_seen) begin
      bad++;
      $display("FAIL %s halt_timeout: HALTED=%b want 1 within %0d cycles", tag, HALTED, cyc + 20);
    end
    total++;
    if (n !== cyc) begin
      bad++;
      $display("FAIL %s run_cycles: got %0d want %0d", tag, n, cyc);
    end
    total++;
    if (PC !== AW'(addr)) begin
      bad++;
      $display("FAIL %s final_pc: got %0d want %0d", tag, PC, addr);
    end
    total++;
    if (ERR !== err_m) begin
      bad++;
      $display("FAIL %s final_err: got %b want %b", tag, ERR, err_m);
    end
    total++;
    if (BUSY !== 1'b0 || ONSWT !== 1'b0) begin
      bad++;
      $display("FAIL %s final_idle: got BUSY=%b ONSWT=%b want 0 0", tag, BUSY, ONSWT);
    end
    total++;
    if (exp_q.size() != 0 || fetch_q.size() != 0) begin
      bad++;
      $display("FAIL %s leftover: got issues=%0d fetches=%0d pending want 0 0", tag, exp_q.size(), fetch_q.size());
    end
  endtask

  task automatic test_reset;
    RSTN = 1'b0;
    repeat (3) step();
    total++;
    if (PC !== 8'd0 || INSTR !== 32'h0) begin
      bad++;
      $display("FAIL reset_pc_instr: got PC=%0d INSTR=%h want 0 0", PC, INSTR);
    end
    total++;
    if (ONSWT !== 1'b0 || IMEM_RD !== 1'b0) begin
      bad++;
      $display("FAIL reset_onswt_rd: got %b %b want 0 0", ONSWT, IMEM_RD);
    end
    total++;
    if (BUSY !== 1'b0 || HALTED !== 1'b0 || ERR !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: got BUSY=%b HALTED=%b ERR=%b want 0 0 0", BUSY, HALTED, ERR);
    end
    RSTN = 1'b1;
    repeat (3) step();
    total++;
    if (BUSY !== 1'b0 || IMEM_RD !== 1'b0) begin
      bad++;
      $display("FAIL idle_hold: got BUSY=%b IMEM_RD=%b want 0 0", BUSY, IMEM_RD);
    end
  endtask

  task automatic test_program;
    fill_mem(32'h7);
    mem[0] = 32'h19;
    mem[1] = 32'h2A;
    mem[2] = 32'h03;
    mem[3] = 32'h84;
    run_program(2, 1'b0, "program");
  endtask

  task automatic test_illegal;
    fill_mem(32'h7);
    mem[0] = 32'h19;
    mem[1] = 32'h06;
    mem[2] = 32'h2A;
    mem[3] = 32'h84;
    run_program(2, 1'b0, "illegal");
  endtask

  task automatic test_done_early;
    fill_mem(32'h7);
    mem[0] = 32'h5A00_0003;
    mem[1] = 32'h0000_0000;
    mem[2] = 32'hC3C3_C384;
    run_program(0, 1'b0, "done_early");
  endtask

  task automatic test_offswt_done;
    fill_mem(32'h7);
    mem[0] = 32'h19;
    mem[1] = 32'h84;
    pulse_start();
    wait_issue("offswt");
    step();
    OFFSWT = 1'b1;
    DONE = 1'b1;
    step();
    OFFSWT = 1'b0;
    DONE = 1'b0;
    total++;
    if (HALTED !== 1'b1 || BUSY !== 1'b0) begin
      bad++;
      $display("FAIL offswt_halt: got HALTED=%b BUSY=%b want 1 0", HALTED, BUSY);
    end
    total++;
    if (ONSWT !== 1'b0 || INSTR !== 32'h0) begin
      bad++;
      $display("FAIL offswt_outputs: got ONSWT=%b INSTR=%h want 0 0", ONSWT, INSTR);
    end
    total++;
    if (PC !== 8'd0) begin
      bad++;
      $display("FAIL offswt_pc: got %0d want 0", PC);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (IMEM_RD !== 1'b0 || HALTED !== 1'b1) begin
        bad++;
        $display("FAIL offswt_stay: got IMEM_RD=%b HALTED=%b want 0 1", IMEM_RD, HALTED);
      end
    end
  endtask

  task automatic test_watchdog;
    int n;
    fill_mem(32'h7);
    mem[0] = 32'h84;
    DONE = 1'b0;
    pulse_start();
    wait_issue("watchdog");
`ifdef SEQ_WATCHDOG_EN
    n = 0;
    while (HALTED !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    total++;
    if (n !== WDT) begin
      bad++;
      $display("FAIL wdt_cycles: got %0d want %0d", n, WDT);
    end
    total++;
    if (ERR !== 1'b1 || ONSWT !== 1'b0 || HALTED !== 1'b1) begin
      bad++;
      $display("FAIL wdt_flags: got ERR=%b ONSWT=%b HALTED=%b want 1 0 1", ERR, ONSWT, HALTED);
    end
`else
    n = 0;
    repeat (1000) begin
      step();
      n++;
    end
    total++;
    if (ONSWT !== 1'b1 || BUSY !== 1'b1 || HALTED !== 1'b0 || ERR !== 1'b0) begin
      bad++;
      $display("FAIL no_wdt_wait: after %0d got ONSWT=%b BUSY=%b HALTED=%b ERR=%b want 1 1 0 0",
               n, ONSWT, BUSY, HALTED, ERR);
    end
    total++;
    if (INSTR !== 32'h84) begin
      bad++;
      $display("FAIL no_wdt_instr: got %h want 84", INSTR);
    end
    OFFSWT = 1'b1;
    step();
    OFFSWT = 1'b0;
    total++;
    if (HALTED !== 1'b1) begin
      bad++;
      $display("FAIL no_wdt_offswt: got HALTED=%b want 1", HALTED);
    end
`endif
  endtask

  task automatic test_reset_mid_run;
    fill_mem(32'h7);
    mem[0] = 32'h06;
    mem[1] = 32'h19;
    mem[2] = 32'h84;
    pulse_start();
    wait_issue("rst_mid");
    total++;
    if (ERR !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_pre_err: got %b want 1", ERR);
    end
    step();
    RSTN = 1'b0;
    step();
    total++;
    if (PC !== 8'd0 || INSTR !== 32'h0 || ONSWT !== 1'b0 || IMEM_RD !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_outputs: got PC=%0d INSTR=%h ONSWT=%b RD=%b want 0 0 0 0",
               PC, INSTR, ONSWT, IMEM_RD);
    end
    total++;
    if (BUSY !== 1'b0 || HALTED !== 1'b0 || ERR !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_flags: got BUSY=%b HALTED=%b ERR=%b want 0 0 0", BUSY, HALTED, ERR);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (IMEM_RD !== 1'b0) begin
        bad++;
        $display("FAIL rst_mid_no_read: got IMEM_RD=%b want 0", IMEM_RD);
      end
    end
    RSTN = 1'b1;
    step();
    pulse_start();
    total++;
    if (IMEM_RD !== 1'b1 || IMEM_ADDR !== 8'd0 || BUSY !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_restart: got RD=%b ADDR=%0d BUSY=%b want 1 0 1", IMEM_RD, IMEM_ADDR, BUSY);
    end
    OFFSWT = 1'b1;
    step();
    OFFSWT = 1'b0;
    total++;
    if (HALTED !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_stop: got HALTED=%b want 1", HALTED);
    end
  endtask

  task automatic test_wrap;
    int k, issues, n;
    bit prev_on, rewritten;
    fill_mem(32'h7);
    mem[0] = 32'h1234_5600;
    pulse_start();
    k = 0; issues = 0; n = 0; prev_on = 0; rewritten = 0;
    while (HALTED !== 1'b1 && n < 2000) begin
      if (IMEM_RD === 1'b1) begin
        total++;
        if (IMEM_ADDR !== AW'(k)) begin
          bad++;
          $display("FAIL wrap_fetch: got %0d want %0d", IMEM_ADDR, AW'(k));
        end
        k++;
      end
      if (ONSWT === 1'b1 && !prev_on) begin
        issues++;
        if (issues == 2) begin
          total++;
          if (INSTR !== 32'hABCD_0084) begin
            bad++;
            $display("FAIL wrap_second_issue: got %h want abcd0084", INSTR);
          end
        end
      end
      if (ONSWT !== 1'b1 && prev_on && !rewritten) begin
        mem[0] = 32'hABCD_0084;
        rewritten = 1;
      end
      prev_on = (ONSWT === 1'b1);
      DONE = (ONSWT === 1'b1);
      step();
      n++;
    end
    DONE = 1'b0;
    total++;
    if (HALTED !== 1'b1 || PC !== 8'd0 || ERR !== 1'b1) begin
      bad++;
      $display("FAIL wrap_end: got HALTED=%b PC=%0d ERR=%b want 1 0 1", HALTED, PC, ERR);
    end
    total++;
    if (k !== DEPTH + 1 || issues !== 2) begin
      bad++;
      $display("FAIL wrap_counts: got fetches=%0d issues=%0d want %0d 2", k, issues, DEPTH + 1);
    end
  endtask

  task automatic test_random;
    int nw, d;
    logic [31:0] w;
    for (int r = 0; r < 8; r++) begin
      nw = $urandom_range(2, 8);
      d = $urandom_range(0, 5);
      fill_mem(32'h7);
      for (int a = 0; a < nw; a++) begin
        w = $urandom;
        w[7] = 1'b0;
        if (a == nw - 1) begin
          w[2:0] = 3'($urandom_range(0, 4));
          w[7] = 1'b1;
        end
        mem[a] = w;
      end
      run_program(d, 1'b1, "random");
    end
  endtask

  initial begin
    IMEM_DATA = 32'h0;
    test_reset();
    test_program();
    test_illegal();
    test_done_early();
    test_offswt_done();
    test_watchdog();
    test_reset_mid_run();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
